// File: rtl/mem_port_arbiter.sv
// Arbitrates the single BRAM port between instruction fetch and load/store.
// One transaction at a time; a release cycle follows each so the memory FSM re-arms.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_address,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_read_write,
  input  logic [1:0]            d_size,
  input  logic                  d_sign,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_input_enable,
  output logic                  mem_read_write,
  output logic [1:0]            mem_size,
  output logic                  mem_sign,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_done_or_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  grant_data,
  output logic                  bus_error
);

  // state     | meaning
  // S_IDLE    | no owner; arbitrate pending requests
  // S_BUSY    | command driven to memory, waiting for done_or_valid or timeout
  // S_RELEASE | enable low one cycle; owner's done pulse is high
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
  localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] streak;
  logic [7:0] tcnt;
  logic       pick_data;
  logic       finish;
  logic       timed_out;

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pick_data = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (d_req || if_req) begin
          state_nxt = S_BUSY;
          // fetch wins a tie only once data has used up its streak allowance
          pick_data = d_req && !(if_req && (streak == STREAK_MAX));
        end
      end
      S_BUSY: begin
        if (mem_done_or_valid) begin
          finish    = 1'b1;
          state_nxt = S_RELEASE;
        end else if (tcnt == TCNT_LAST) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign mem_input_enable = (state == S_BUSY);

  always_ff @(posedge clock) begin
    if (!reset) begin
      streak         <= '0;
      tcnt           <= '0;
      grant_data     <= 1'b0;
      mem_read_write <= 1'b0;
      mem_size       <= '0;
      mem_sign       <= 1'b0;
      mem_address    <= '0;
      mem_wdata      <= '0;
      if_done        <= 1'b0;
      if_rdata       <= '0;
      d_done         <= 1'b0;
      d_rdata        <= '0;
      bus_error      <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;

      if (state == S_IDLE && state_nxt == S_BUSY) begin
        tcnt       <= '0;
        grant_data <= pick_data;
        if (pick_data) begin
          if (streak != STREAK_MAX) streak <= streak + 4'd1;
          mem_read_write <= d_read_write;
          mem_size       <= d_size;
          mem_sign       <= d_sign;
          mem_address    <= d_address;
          mem_wdata      <= d_wdata;
        end else begin
          streak         <= '0;
          mem_read_write <= 1'b0;
          mem_size       <= 2'd2;
          mem_sign       <= 1'b0;
          mem_address    <= if_address;
          mem_wdata      <= '0;
        end
      end

      if (state == S_BUSY && !finish) tcnt <= tcnt + 8'd1;

      if (finish) begin
        if (timed_out) bus_error <= 1'b1;
        if (grant_data) begin
          d_done  <= 1'b1;
          d_rdata <= (timed_out || mem_read_write) ? '0 : mem_rdata;
        end else begin
          if_done  <= 1'b1;
          if_rdata <= timed_out ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small latency-programmable memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_address;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_read_write;
  logic [1:0]  d_size;
  logic        d_sign;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_input_enable;
  logic        mem_read_write;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_done_or_valid;
  logic [31:0] mem_rdata;
  logic        grant_data;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  // memory model controls and captured command
  logic        respond = 1'b0;
  int          delay = 1;
  logic [31:0] resp_data = '0;
  int          cnt = 0;
  int          en_cycles = 0;
  logic        gq[$];
  logic        cap_rw;
  logic [1:0]  cap_size;
  logic        cap_sign;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_STREAK(4), .TIMEOUT(64)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_address(if_address), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_read_write(d_read_write), .d_size(d_size), .d_sign(d_sign),
    .d_address(d_address), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .mem_input_enable(mem_input_enable), .mem_read_write(mem_read_write),
    .mem_size(mem_size), .mem_sign(mem_sign), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_done_or_valid(mem_done_or_valid), .mem_rdata(mem_rdata),
    .grant_data(grant_data), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  initial begin
    mem_done_or_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_input_enable) begin
        if (cnt == 0) begin
          gq.push_back(grant_data);
          cap_rw = mem_read_write; cap_size = mem_size; cap_sign = mem_sign;
          cap_addr = mem_address; cap_wdata = mem_wdata;
        end
        cnt = cnt + 1;
        en_cycles = cnt;
        mem_done_or_valid = respond && (cnt == delay);
        mem_rdata = resp_data;
      end else begin
        cnt = 0;
        mem_done_or_valid = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit data_side, output bit found);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (data_side ? d_done : if_done) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  int exp_g[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  bit found;

  initial begin
    reset = 1'b0;
    if_req = 0; if_address = '0;
    d_req = 0; d_read_write = 0; d_size = '0; d_sign = 0; d_address = '0; d_wdata = '0;
    repeat (3) @(negedge clock);
    check("rst_enable", 32'(mem_input_enable), 0);
    check("rst_if_done", 32'(if_done), 0);
    check("rst_d_done", 32'(d_done), 0);
    check("rst_grant", 32'(grant_data), 0);
    check("rst_bus_error", 32'(bus_error), 0);
    check("rst_mem_size", 32'(mem_size), 0);
    reset = 1'b1;
    @(negedge clock);

    // fetch from 0x8, four-cycle memory
    respond = 1; delay = 4; resp_data = 32'h0020_8133; gq.delete();
    if_req = 1; if_address = 32'h8;
    wait_done(0, found);
    check("fetch_done_seen", 32'(found), 1);
    check("fetch_rdata", if_rdata, 32'h0020_8133);
    check("fetch_en_cycles", 32'(en_cycles), 4);
    check("fetch_en_low_at_done", 32'(mem_input_enable), 0);
    check("fetch_addr", cap_addr, 32'h8);
    check("fetch_rw", 32'(cap_rw), 0);
    check("fetch_size", 32'(cap_size), 2);
    check("fetch_grant", 32'(gq[0]), 0);
    if_req = 0;
    @(negedge clock);
    check("fetch_done_one_cycle", 32'(if_done), 0);
    check("fetch_en_release_low", 32'(mem_input_enable), 0);
    repeat (2) @(negedge clock);

    // both requesters held continuously
    delay = 1; resp_data = 32'h1; gq.delete();
    d_req = 1; if_req = 1; d_address = 32'h40;
    for (int i = 0; i < 400 && gq.size() < 10; i++) @(negedge clock);
    d_req = 0; if_req = 0;
    repeat (6) @(negedge clock);
    check("arb_count", 32'(gq.size()), 10);
    for (int i = 0; i < 10; i++)
      if (i < gq.size()) check($sformatf("arb_grant_%0d", i), 32'(gq[i]), 32'(exp_g[i]));

    // signed byte load
    delay = 3; resp_data = 32'hFFFF_FF80; gq.delete();
    d_req = 1; d_read_write = 0; d_size = 0; d_sign = 1; d_address = 32'h4; d_wdata = 32'h5555_5555;
    wait_done(1, found);
    check("load_done_seen", 32'(found), 1);
    check("load_rdata", d_rdata, 32'hFFFF_FF80);
    check("load_size", 32'(cap_size), 0);
    check("load_sign", 32'(cap_sign), 1);
    check("load_addr", cap_addr, 32'h4);
    check("load_grant", 32'(grant_data), 1);
    check("if_rdata_held", if_rdata, 32'h1);
    d_req = 0;
    @(negedge clock);
    check("load_done_one_cycle", 32'(d_done), 0);
    repeat (2) @(negedge clock);

    // store
    delay = 2; resp_data = 32'h1234_5678; gq.delete();
    d_req = 1; d_read_write = 1; d_size = 2; d_sign = 0; d_address = 32'h10; d_wdata = 32'hDEAD_BEEF;
    wait_done(1, found);
    check("store_done_seen", 32'(found), 1);
    check("store_rdata_zero", d_rdata, 0);
    check("store_rw", 32'(cap_rw), 1);
    check("store_wdata", cap_wdata, 32'hDEAD_BEEF);
    check("store_addr", cap_addr, 32'h10);
    d_req = 0;
    repeat (3) @(negedge clock);

    // memory never answers
    respond = 0; gq.delete();
    d_req = 1; d_read_write = 0; d_size = 2; d_address = 32'h20;
    wait_done(1, found);
    check("timeout_done_seen", 32'(found), 1);
    check("timeout_en_cycles", 32'(en_cycles), 64);
    check("timeout_rdata", d_rdata, 0);
    check("timeout_bus_error", 32'(bus_error), 1);
    d_req = 0;
    repeat (4) @(negedge clock);
    check("bus_error_sticky", 32'(bus_error), 1);

    // reset while busy, then reissue
    if_req = 1; if_address = 32'hC;
    repeat (3) @(negedge clock);
    check("pre_reset_busy", 32'(mem_input_enable), 1);
    reset = 0;
    @(negedge clock);
    check("midrst_enable", 32'(mem_input_enable), 0);
    check("midrst_if_done", 32'(if_done), 0);
    check("midrst_if_rdata", if_rdata, 0);
    check("midrst_bus_error", 32'(bus_error), 0);
    check("midrst_mem_addr", mem_address, 0);
    respond = 1; delay = 2; resp_data = 32'hCAFE_F00D;
    @(negedge clock);
    check("midrst_if_done_2", 32'(if_done), 0);
    reset = 1;
    wait_done(0, found);
    check("reissue_done_seen", 32'(found), 1);
    check("reissue_rdata", if_rdata, 32'hCAFE_F00D);
    check("reissue_addr", cap_addr, 32'hC);
    check("reissue_bus_error", 32'(bus_error), 0);
    if_req = 0;
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
